// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity
// (compiled in with `define UART_TX_PARITY_EN), STOP_BITS stop bits, all outputs registered.
module uart_tx_param #(
   parameter int CLKS_PER_BIT = 87,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Rst_L,
   input  logic                 i_Tx_DV,
   input  logic [DATA_BITS-1:0] i_Tx_Byte,
   input  logic                 i_Parity_Odd,
   output logic                 o_Tx_Ready,
   output logic                 o_Tx_Active,
   output logic                 o_Tx_Serial,
   output logic                 o_Tx_Done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
      S_PARITY  = 3'd3,
      S_STOP    = 3'd4,
      S_CLEANUP = 3'd5
   } state_e;

   state_e                 state_q, state_d;
   logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
   logic [BW-1:0]          bit_idx_q, bit_idx_d;
   logic                   stop_cnt_q, stop_cnt_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   serial_q, serial_d;
   logic                   ready_q, ready_d;
   logic                   active_q, active_d;
   logic                   done_q, done_d;
   logic                   bit_end;

`ifdef UART_TX_PARITY_EN
   // The parity bit is resolved at acceptance, so the data register is free to shift.
   logic                   parity_q, parity_d;
`else
   logic                   unused_parity_odd;
   assign unused_parity_odd = i_Parity_Odd;
`endif

   assign bit_end = (clk_cnt_q == CNT_LAST);

   always_comb begin
      // NOTE: every next-state signal is defaulted to its held value first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_d    = state_q;
      clk_cnt_d  = clk_cnt_q;
      bit_idx_d  = bit_idx_q;
      stop_cnt_d = stop_cnt_q;
      data_d     = data_q;
      serial_d   = serial_q;
      ready_d    = ready_q;
      active_d   = active_q;
      done_d     = done_q;
`ifdef UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif

      case (state_q)
         S_IDLE: begin
            serial_d   = 1'b1;
            ready_d    = 1'b1;
            active_d   = 1'b0;
            done_d     = 1'b0;
            clk_cnt_d  = '0;
            bit_idx_d  = '0;
            stop_cnt_d = 1'b0;
            if (i_Tx_DV && ready_q) begin
               data_d   = i_Tx_Byte;
`ifdef UART_TX_PARITY_EN
               parity_d = ^i_Tx_Byte ^ i_Parity_Odd;
`endif
               state_d  = S_START;
               serial_d = 1'b0;
               ready_d  = 1'b0;
               active_d = 1'b1;
            end
         end

         S_START: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               state_d   = S_DATA;
               serial_d  = data_q[0];
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end

         S_DATA: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               if (bit_idx_q == BIT_LAST) begin
                  bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = S_PARITY;
                  serial_d  = parity_q;
`else
                  state_d   = S_STOP;
                  serial_d  = 1'b1;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + BW'(1);
                  data_d    = data_q >> 1;
                  serial_d  = data_q[1];
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end

`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               state_d   = S_STOP;
               serial_d  = 1'b1;
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end
`endif

         S_STOP: begin
            serial_d = 1'b1;
            if (bit_end) begin
               clk_cnt_d = '0;
               if (stop_cnt_q == STOP_LAST) begin
                  stop_cnt_d = 1'b0;
                  state_d    = S_CLEANUP;
                  active_d   = 1'b0;
                  done_d     = 1'b1;
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end

         S_CLEANUP: begin
            state_d  = S_IDLE;
            serial_d = 1'b1;
            done_d   = 1'b0;
            ready_d  = 1'b1;
         end

         default: begin
            state_d    = S_IDLE;
            serial_d   = 1'b1;
            ready_d    = 1'b1;
            active_d   = 1'b0;
            done_d     = 1'b0;
            clk_cnt_d  = '0;
            bit_idx_d  = '0;
            stop_cnt_d = 1'b0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values, independent of process evaluation order.
   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q    <= S_IDLE;
         clk_cnt_q  <= '0;
         bit_idx_q  <= '0;
         stop_cnt_q <= 1'b0;
         data_q     <= '0;
         serial_q   <= 1'b1;
         ready_q    <= 1'b1;
         active_q   <= 1'b0;
         done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         clk_cnt_q  <= clk_cnt_d;
         bit_idx_q  <= bit_idx_d;
         stop_cnt_q <= stop_cnt_d;
         data_q     <= data_d;
         serial_q   <= serial_d;
         ready_q    <= ready_d;
         active_q   <= active_d;
         done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign o_Tx_Serial = serial_q;
   assign o_Tx_Ready  = ready_q;
   assign o_Tx_Active = active_q;
   assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: two instances (8-bit/1-stop and 5-bit/2-stop, 4 clocks per bit),
// expected line frames queued at request time and checked cycle by cycle by per-instance monitors.
module tb_uart_tx_param;

   localparam int C = 4;

   typedef struct {
      logic [15:0] bits;
      int          nbits;
      int          gap;
      bit          abort;
      logic        par;
      string       name;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] dv, odd, ser, act, dn, rdy;
   logic [7:0] byte0;
   logic [4:0] byte1;
   int         cyc = 0;
   int         acc_cyc [2];
   int         checks = 0;
   int         errors = 0;
   frame_t     q0[$];
   frame_t     q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1)) dut0 (
      .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv[0]), .i_Tx_Byte(byte0),
      .i_Parity_Odd(odd[0]), .o_Tx_Ready(rdy[0]), .o_Tx_Active(act[0]),
      .o_Tx_Serial(ser[0]), .o_Tx_Done(dn[0]));

   uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(5), .STOP_BITS(2)) dut1 (
      .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv[1]), .i_Tx_Byte(byte1),
      .i_Parity_Odd(odd[1]), .o_Tx_Ready(rdy[1]), .o_Tx_Active(act[1]),
      .o_Tx_Serial(ser[1]), .o_Tx_Done(dn[1]));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Line image: start, data LSB first, parity when compiled in, stop bits.
   function automatic frame_t mk(input string name, input logic [7:0] d, input int dbits,
                                 input int sbits, input logic par, input int gap, input bit abort);
      frame_t f;
      int     n = 0;
      f.bits = '0;
      f.bits[n] = 1'b0;
      n++;
      for (int i = 0; i < dbits; i++) begin
         f.bits[n] = d[i];
         n++;
      end
`ifdef UART_TX_PARITY_EN
      f.bits[n] = par;
      n++;
`endif
      for (int i = 0; i < sbits; i++) begin
         f.bits[n] = 1'b1;
         n++;
      end
      f.nbits = n;
      f.gap   = gap;
      f.abort = abort;
      f.par   = par;
      f.name  = name;
      return f;
   endfunction

   task automatic monitor(input int id);
      frame_t f;
      int     idle = 0;
      bit     aborted;
      logic   got_s, got_a;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            idle = 0;
            continue;
         end
         if (dn[id] !== 1'b0) check($sformatf("dut%0d_stray_done", id), dn[id], 1'b0);
         if (ser[id] !== 1'b0) begin
            idle++;
            continue;
         end
         if ((id == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            flag($sformatf("dut%0d_unexpected_frame", id));
            for (int k = 0; k < 200 && ser[id] === 1'b0; k++) @(negedge clk);
            idle = 0;
            continue;
         end
         if (id == 0) f = q0.pop_front();
         else f = q1.pop_front();
         check({f.name, "_latency"}, cyc - acc_cyc[id], 0);
         if (f.gap >= 0) check({f.name, "_gap"}, idle, f.gap);
         aborted = 1'b0;
         for (int b = 0; b < f.nbits && !aborted; b++) begin
            got_s = f.bits[b];
            got_a = 1'b1;
            for (int k = 0; k < C; k++) begin
               if (k > 0 || b > 0) @(negedge clk);
               if (!rst_n) begin
                  aborted = 1'b1;
                  break;
               end
               if (ser[id] !== f.bits[b]) got_s = ser[id];
               if (act[id] !== 1'b1) got_a = act[id];
            end
            if (!aborted) begin
               check($sformatf("%s_bit%0d_line", f.name, b), got_s, f.bits[b]);
               check($sformatf("%s_bit%0d_active", f.name, b), got_a, 1'b1);
            end
         end
         if (aborted) begin
            if (!f.abort) flag({f.name, "_unexpected_abort"});
            check({f.name, "_rst_line"}, ser[id], 1'b1);
            check({f.name, "_rst_active"}, act[id], 1'b0);
            check({f.name, "_rst_done"}, dn[id], 1'b0);
            check({f.name, "_rst_ready"}, rdy[id], 1'b1);
            for (int k = 0; k < 100 && !rst_n; k++) begin
               @(negedge clk);
               check({f.name, "_rst_hold_done"}, dn[id], 1'b0);
            end
            idle = 0;
         end else begin
            if (f.abort) flag({f.name, "_abort_missing"});
            @(negedge clk);
            check({f.name, "_done_pulse"}, dn[id], 1'b1);
            check({f.name, "_cleanup_line"}, ser[id], 1'b1);
            check({f.name, "_cleanup_active"}, act[id], 1'b0);
            check({f.name, "_cleanup_ready"}, rdy[id], 1'b0);
            @(negedge clk);
            check({f.name, "_done_cleared"}, dn[id], 1'b0);
            check({f.name, "_ready_back"}, rdy[id], 1'b1);
            idle = 2;
         end
      end
   endtask

   task automatic send(input int id, input logic [7:0] d, input logic o, input bit keep);
      int t = 0;
      dv[id]  = 1'b1;
      odd[id] = o;
      if (id == 0) byte0 = d;
      else byte1 = d[4:0];
      do begin
         @(posedge clk);
         t++;
      end while (rdy[id] !== 1'b1 && t < 500);
      if (rdy[id] !== 1'b1) flag($sformatf("dut%0d_accept_timeout", id));
      #1;
      acc_cyc[id] = cyc;
      if (!keep) dv[id] = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((q0.size() != 0 || q1.size() != 0 || rdy !== 2'b11) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) flag("drain_timeout");
      repeat (4) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      dv    = '0;
      odd   = '0;
      byte0 = '0;
      byte1 = '0;
      fork
         monitor(0);
         monitor(1);
      join_none

      repeat (3) @(posedge clk);
      #2;
      check("reset_line", ser, 2'b11);
      check("reset_ready", rdy, 2'b11);
      check("reset_active", act, 2'b00);
      check("reset_done", dn, 2'b00);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_line_after_reset", ser, 2'b11);

      // 0xA5 has four ones: even parity 0, odd parity 1.
      q0.push_back(mk("a5_even", 8'hA5, 8, 1, 1'b0, -1, 1'b0));
      send(0, 8'hA5, 1'b0, 1'b0);
      wait_idle();
      q0.push_back(mk("a5_odd", 8'hA5, 8, 1, 1'b1, -1, 1'b0));
      send(0, 8'hA5, 1'b1, 1'b0);
      wait_idle();

      // 5-bit 0x13 = 1,1,0,0,1 (three ones): even parity 1, odd parity 0.
      q1.push_back(mk("x13_even", 8'h13, 5, 2, 1'b1, -1, 1'b0));
      send(1, 8'h13, 1'b0, 1'b0);
      wait_idle();
      q1.push_back(mk("x13_odd", 8'h13, 5, 2, 1'b0, -1, 1'b0));
      send(1, 8'h13, 1'b1, 1'b0);
      wait_idle();

      // Back-to-back with DV held; the byte changes to 0xFF mid-frame of 0x00.
      q0.push_back(mk("b2b_00", 8'h00, 8, 1, 1'b0, -1, 1'b0));
      q0.push_back(mk("b2b_ff", 8'hFF, 8, 1, 1'b0, 2, 1'b0));
      send(0, 8'h00, 1'b0, 1'b1);
      send(0, 8'hFF, 1'b0, 1'b0);
      repeat (8) @(negedge clk);
      dv[0] = 1'b1;
      byte0 = 8'h3C;
      @(negedge clk);
      dv[0] = 1'b0;
      wait_idle();
      repeat (20) @(negedge clk);

      // Reset in the second cycle of data bit 3, then a clean frame.
      q0.push_back(mk("abort_5a", 8'h5A, 8, 1, 1'b0, -1, 1'b1));
      send(0, 8'h5A, 1'b0, 1'b0);
      repeat (4 * C + 1) @(posedge clk);
      #2;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      q0.push_back(mk("after_rst_c3", 8'hC3, 8, 1, 1'b0, -1, 1'b0));
      send(0, 8'hC3, 1'b0, 1'b0);
      wait_idle();

      repeat (10) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
